control_unit: RTL and testbench

Multi-cycle sequencer for the 16-bit processing unit. Fetches, decodes and executes instructions by driving the datapath's ALU operation, bus-A source, single register write-enable select, DR input source and RAM read/write strobes each cycle. Sits between the UART program loader, the RAM and the processing unit. Starts once the loader reports completion and stops on END or an illegal opcode.

---
 rtl/cu_pkg.sv | 41 ++++
 rtl/cu_decode.sv | 39 +++
 rtl/control_unit.sv | 123 ++++++++++++
 tb/tb_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the control_unit sequencer: opcodes, datapath
// select codes and the FSM state set.
package cu_pkg;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LDAC  = 6'd1;
    localparam logic [5:0] OP_STAC  = 6'd2;
    localparam logic [5:0] OP_MVACR = 6'd3;
    localparam logic [5:0] OP_ADD   = 6'd4;
    localparam logic [5:0] OP_SUB   = 6'd5;
    localparam logic [5:0] OP_INAC  = 6'd6;
    localparam logic [5:0] OP_CLAC  = 6'd7;
    localparam logic [5:0] OP_JUMP  = 6'd8;
    localparam logic [5:0] OP_JMPZ  = 6'd9;
    localparam logic [5:0] OP_JMPNZ = 6'd10;
    localparam logic [5:0] OP_END   = 6'd63;

    typedef enum logic [2:0] {
        ALU_PASS, ALU_ADD, ALU_SUB, ALU_INC, ALU_CLR
    } alu_op_e;

    typedef enum logic [2:0] {
        BUS_AC, BUS_AR, BUS_PC, BUS_DR, BUS_TR
    } bus_sel_e;

    typedef enum logic [2:0] {
        WE_NONE, WE_AC, WE_AR, WE_DR, WE_IR, WE_PC, WE_R, WE_TR
    } we_sel_e;

    typedef enum logic [4:0] {
        S_IDLE,
        S_F1, S_F2, S_F3, S_F4, S_F5, S_DEC,
        S_O1, S_O2, S_O3, S_O4,
        S_L1, S_L2, S_L3, S_L4,
        S_S1, S_S2, S_S3,
        S_J1,
        S_MV, S_AD, S_SB, S_IN, S_CL,
        S_HALT, S_HALT_ILL
    } state_e;

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: first execute state, state after operand fetch, illegal flag.
// Conditional jumps exist only when CU_COND_JUMP_EN is defined.
module cu_decode
    import cu_pkg::*;
(
    input  logic [5:0] op_i,
`ifdef CU_COND_JUMP_EN
    input  logic       z_i,
`endif
    output state_e     first_o,
    output state_e     post_o,
    output logic       illegal_o
);

    always_comb begin
        first_o = S_HALT_ILL;
        post_o  = S_F1;
        case (op_i)
            OP_NOP:   first_o = S_F1;
            OP_LDAC:  begin first_o = S_O1; post_o = S_L1; end
            OP_STAC:  begin first_o = S_O1; post_o = S_S1; end
            OP_JUMP:  begin first_o = S_O1; post_o = S_J1; end
            OP_MVACR: first_o = S_MV;
            OP_ADD:   first_o = S_AD;
            OP_SUB:   first_o = S_SB;
            OP_INAC:  first_o = S_IN;
            OP_CLAC:  first_o = S_CL;
`ifdef CU_COND_JUMP_EN
            OP_JMPZ:  begin first_o = S_O1; post_o = z_i ? S_J1 : S_F1; end
            OP_JMPNZ: begin first_o = S_O1; post_o = z_i ? S_F1 : S_J1; end
`endif
            OP_END:   first_o = S_HALT;
            default:  first_o = S_HALT_ILL;
        endcase
    end

    assign illegal_o = (first_o == S_HALT_ILL);

endmodule

// File: rtl/control_unit.sv
// Moore multi-cycle sequencer for the 16-bit processing unit.
// Optional conditional jumps: define CU_COND_JUMP_EN.
module control_unit
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART2RAMCompleted,
    input  logic [5:0] IROut,
    input  logic       Z,
    output logic [2:0] ALUControlSignal,
    output logic [2:0] busAMuxSelect,
    output logic [2:0] writeEnableSelect,
    output logic       zClear,
    output logic       RAMorALUOut2DRIn,
    output logic       ramRead,
    output logic       ramWrite,
    output logic       halted,
    output logic       illegalOp
);

    state_e   state_q, state_d;
    state_e   first, post;
    logic     illegal;
    alu_op_e  alu;
    bus_sel_e bus;
    we_sel_e  we;
    logic     wr;

    cu_decode u_decode (
        .op_i      (IROut),
`ifdef CU_COND_JUMP_EN
        .z_i       (Z),
`endif
        .first_o   (first),
        .post_o    (post),
        .illegal_o (illegal)
    );

`ifndef CU_COND_JUMP_EN
    logic unused_z;
    assign unused_z = Z;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!UART2RAMCompleted) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     state_d = S_F1;
                S_F1:       state_d = S_F2;
                S_F2:       state_d = S_F3;
                S_F3:       state_d = S_F4;
                S_F4:       state_d = S_F5;
                S_F5:       state_d = S_DEC;
                S_DEC:      state_d = illegal ? S_HALT_ILL : first;
                S_O1:       state_d = S_O2;
                S_O2:       state_d = S_O3;
                S_O3:       state_d = S_O4;
                S_O4:       state_d = post;
                S_L1:       state_d = S_L2;
                S_L2:       state_d = S_L3;
                S_L3:       state_d = S_L4;
                S_S1:       state_d = S_S2;
                S_S2:       state_d = S_S3;
                S_HALT:     state_d = S_HALT;
                S_HALT_ILL: state_d = S_HALT_ILL;
                S_L4, S_S3, S_J1, S_MV,
                S_AD, S_SB, S_IN, S_CL:
                            state_d = S_F1;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu              = ALU_PASS;
        bus              = BUS_AC;
        we               = WE_NONE;
        zClear           = 1'b0;
        RAMorALUOut2DRIn = 1'b0;
        ramRead          = 1'b0;
        wr               = 1'b0;
        halted           = 1'b0;
        illegalOp        = 1'b0;
        case (state_q)
            S_IDLE:       zClear = 1'b1;
            S_F1, S_O1:   begin bus = BUS_PC; we = WE_AR; end
            S_F2, S_O2,
            S_L2:         ramRead = 1'b1;
            S_F3, S_O3,
            S_L3:         begin RAMorALUOut2DRIn = 1'b1; we = WE_DR; end
            S_F4:         begin bus = BUS_DR; we = WE_IR; end
            S_F5, S_O4:   begin bus = BUS_PC; alu = ALU_INC; we = WE_PC; end
            S_L1, S_S1:   begin bus = BUS_DR; we = WE_AR; end
            S_L4:         begin bus = BUS_DR; we = WE_AC; end
            S_S2:         we = WE_DR;
            S_S3:         wr = 1'b1;
            S_J1:         begin bus = BUS_DR; we = WE_PC; end
            S_MV:         we = WE_R;
            S_AD:         begin alu = ALU_ADD; we = WE_AC; end
            S_SB:         begin alu = ALU_SUB; we = WE_AC; end
            S_IN:         begin alu = ALU_INC; we = WE_AC; end
            S_CL:         begin alu = ALU_CLR; we = WE_AC; end
            S_HALT:       halted = 1'b1;
            S_HALT_ILL:   begin halted = 1'b1; illegalOp = 1'b1; end
            default:      ;
        endcase
    end

    // Reset kills a pending write in the same cycle, before any clock edge.
    assign ramWrite          = wr & rst_n;
    assign ALUControlSignal  = alu;
    assign busAMuxSelect     = bus;
    assign writeEnableSelect = we;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: expected per-cycle output
// vectors are queued per instruction and popped on each falling edge.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart;
    logic [5:0] ir;
    logic       z;
    logic [2:0] alu, bus, we;
    logic       zc, drs, rd, wr, hlt, ill;

    int errors = 0;
    int checks = 0;

    logic [14:0] expq[$];

    localparam logic [5:0] FZC = 6'b100000;
    localparam logic [5:0] FDR = 6'b010000;
    localparam logic [5:0] FRD = 6'b001000;
    localparam logic [5:0] FWR = 6'b000100;
    localparam logic [5:0] FH  = 6'b000010;
    localparam logic [5:0] FIL = 6'b000001;

    control_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .UART2RAMCompleted (uart),
        .IROut             (ir),
        .Z                 (z),
        .ALUControlSignal  (alu),
        .busAMuxSelect     (bus),
        .writeEnableSelect (we),
        .zClear            (zc),
        .RAMorALUOut2DRIn  (drs),
        .ramRead           (rd),
        .ramWrite          (wr),
        .halted            (hlt),
        .illegalOp         (ill)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] v(
        input logic [2:0] a, input logic [2:0] b,
        input logic [2:0] w, input logic [5:0] f);
        return {a, b, w, f};
    endfunction

    function automatic logic [14:0] obs();
        return {alu, bus, we, zc, drs, rd, wr, hlt, ill};
    endfunction

    task automatic check(input string tag, input int n, input logic [14:0] e);
        logic [14:0] o;
        o = obs();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc%0d observed=%h expected=%h", tag, n, o, e);
        end
    endtask

    task automatic push_fetch();
        expq.push_back(v(0, 2, 2, 0));
        expq.push_back(v(0, 0, 0, FRD));
        expq.push_back(v(0, 0, 3, FDR));
        expq.push_back(v(0, 3, 4, 0));
        expq.push_back(v(3, 2, 5, 0));
        expq.push_back(v(0, 0, 0, 0));
    endtask

    task automatic push_opnd();
        expq.push_back(v(0, 2, 2, 0));
        expq.push_back(v(0, 0, 0, FRD));
        expq.push_back(v(0, 0, 3, FDR));
        expq.push_back(v(3, 2, 5, 0));
    endtask

    // Drains the queue one cycle per entry; opcode/Z are driven during F1.
    task automatic run(input string tag, input logic [5:0] op, input logic zv,
                       input bit set_op);
        int n;
        n = 1;
        while (expq.size() > 0) begin
            @(negedge clk);
            if (set_op && n == 1) begin
                ir = op;
                z  = zv;
            end
            check(tag, n, expq.pop_front());
            n++;
        end
    endtask

    task automatic alu_instr(input string tag, input logic [5:0] op,
                             input logic [2:0] a, input logic [2:0] w);
        push_fetch();
        expq.push_back(v(a, 0, w, 0));
        run(tag, op, 1'b0, 1'b1);
    endtask

    task automatic halt_instr(input string tag, input logic [5:0] op,
                              input logic [5:0] f);
        push_fetch();
        for (int i = 0; i < 3; i++) expq.push_back(v(0, 0, 0, f));
        run(tag, op, 1'b0, 1'b1);
        uart = 1'b0;
        expq.push_back(v(0, 0, 0, FZC));
        expq.push_back(v(0, 0, 0, FZC));
        run({tag, "_recover"}, 6'd0, 1'b0, 1'b0);
        uart = 1'b1;
    endtask

    task automatic jmp_instr(input string tag, input logic [5:0] op,
                             input logic zv, input bit taken);
        push_fetch();
        push_opnd();
        if (taken) expq.push_back(v(0, 3, 5, 0));
        run(tag, op, zv, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        uart  = 1'b1;
        ir    = 6'd0;
        z     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_idle", 0, v(0, 0, 0, FZC));
        rst_n = 1'b1;

        push_fetch();
        run("nop", 6'd0, 1'b0, 1'b1);

        push_fetch();
        push_opnd();
        expq.push_back(v(0, 3, 2, 0));
        expq.push_back(v(0, 0, 0, FRD));
        expq.push_back(v(0, 0, 3, FDR));
        expq.push_back(v(0, 3, 1, 0));
        run("ldac", 6'd1, 1'b0, 1'b1);

        push_fetch();
        push_opnd();
        expq.push_back(v(0, 3, 2, 0));
        expq.push_back(v(0, 0, 3, 0));
        expq.push_back(v(0, 0, 0, FWR));
        run("stac", 6'd2, 1'b0, 1'b1);

        jmp_instr("jump", 6'd8, 1'b0, 1'b1);

        alu_instr("mvacr", 6'd3, 3'd0, 3'd6);
        alu_instr("add",   6'd4, 3'd1, 3'd1);
        alu_instr("sub",   6'd5, 3'd2, 3'd1);
        alu_instr("inac",  6'd6, 3'd3, 3'd1);
        alu_instr("clac",  6'd7, 3'd4, 3'd1);

`ifdef CU_COND_JUMP_EN
        jmp_instr("jmpz_z1",  6'd9,  1'b1, 1'b1);
        jmp_instr("jmpz_z0",  6'd9,  1'b0, 1'b0);
        jmp_instr("jmpnz_z1", 6'd10, 1'b1, 1'b0);
        jmp_instr("jmpnz_z0", 6'd10, 1'b0, 1'b1);
`else
        halt_instr("jmpz_ill",  6'd9,  FH | FIL);
        halt_instr("jmpnz_ill", 6'd10, FH | FIL);
`endif

        halt_instr("illegal_2a", 6'h2A, FH | FIL);
        halt_instr("end", 6'd63, FH);

        // STAC again, with reset applied while the write strobe is high.
        push_fetch();
        push_opnd();
        expq.push_back(v(0, 3, 2, 0));
        expq.push_back(v(0, 0, 3, 0));
        expq.push_back(v(0, 0, 0, FWR));
        run("stac_rst", 6'd2, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("rst_in_s3", 0, v(0, 0, 0, FZC));
        @(negedge clk);
        check("rst_hold", 0, v(0, 0, 0, FZC));
        rst_n = 1'b1;

        push_fetch();
        run("nop_after_rst", 6'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
